// File: rtl/bcd_counter_3digits.sv
// Three-digit BCD up-counter with latched seven-segment displays.
// The count increments in decimal when enabled and wraps 999 -> 000 in one
// step. A separate bank of display registers snapshots the post-edge count
// whenever ld is high, and each display register is decoded combinationally
// to an active-low seven-segment code (bit6=g ... bit0=a).
module bcd_counter_3digits (
    input  logic       ck,
    input  logic       rst_s,
    input  logic       ld,
    input  logic       enb,
    output logic [6:0] sgm0,
    output logic [6:0] sgm1,
    output logic [6:0] sgm2,
    output logic       cnt_9
);

    // Digit index 0 = units, 1 = tens, 2 = hundreds.
    logic [2:0][3:0] cnt_q;
    logic [2:0][3:0] cnt_d;
    logic [2:0][3:0] disp_q;
    logic [2:0][3:0] disp_d;
    logic [2:0][6:0] seg_w;
    logic            carry;

    // Active-low segment decode; anything outside 0-9 blanks the digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Ripple decimal increment across the digits and select the display load value.
    always_comb begin
        cnt_d = cnt_q;
        carry = enb;
        for (int i = 0; i < 3; i++) begin
            if (cnt_q[i] > 4'd9) begin
                // Scrub an illegal digit so the count can never stay non-BCD.
                cnt_d[i] = 4'd0;
            end else if (carry) begin
                if (cnt_q[i] == 4'd9) begin
                    cnt_d[i] = 4'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                    carry    = 1'b0;
                end
            end
        end
        // Displays take the value being written to the count on this edge.
        disp_d = ld ? cnt_d : disp_q;
    end

    // State registers; reset has priority over enable and latch.
    always_ff @(posedge ck) begin
        if (!rst_s) begin
            cnt_q  <= '0;
            disp_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            disp_q <= disp_d;
        end
    end

    // One decoder per display digit; forced to "0" while reset is held.
    for (genvar gi = 0; gi < 3; gi++) begin : g_seg
        assign seg_w[gi] = rst_s ? seg_decode(disp_q[gi]) : 7'h40;
    end

    assign sgm0  = seg_w[0];
    assign sgm1  = seg_w[1];
    assign sgm2  = seg_w[2];

    // Terminal count: asserted in the cycle before an enabled wrap.
    assign cnt_9 = rst_s & enb & (cnt_q == 12'h999);

endmodule

// File: tb/tb_bcd_counter_3digits.sv
// Testbench for bcd_counter_3digits: a table of multi-cycle steps with
// hand-written expected segment codes, plus a per-cycle scoreboard fed by an
// integer reference model of the count and display registers.
module tb_bcd_counter_3digits;

    logic       ck = 1'b0;
    logic       rst_s = 1'b0;
    logic       ld = 1'b0;
    logic       enb = 1'b0;
    logic [6:0] sgm0, sgm1, sgm2;
    logic       cnt_9;

    int total = 0;
    int bad   = 0;

    // Reference model state (plain integers, 0..999).
    int m_cnt  = 0;
    int m_disp = 0;

    typedef struct {
        logic [6:0] s2;
        logic [6:0] s1;
        logic [6:0] s0;
        logic       c9;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        string      name;
        logic       rst;
        logic       l;
        logic       e;
        int         reps;
        logic [6:0] s2;
        logic [6:0] s1;
        logic [6:0] s0;
        logic       c9;
    } vec_t;

    vec_t vecs[15];

    bcd_counter_3digits dut (
        .ck    (ck),
        .rst_s (rst_s),
        .ld    (ld),
        .enb   (enb),
        .sgm0  (sgm0),
        .sgm1  (sgm1),
        .sgm2  (sgm2),
        .cnt_9 (cnt_9)
    );

    always #5 ck = ~ck;

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return t[d];
    endfunction

    task automatic check7(input string name, input logic [6:0] act, input logic [6:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // Drive one cycle, push the model's prediction, then pop and compare after the edge.
    task automatic step(input logic r, input logic l, input logic e);
        exp_t x;
        exp_t got;
        rst_s = r;
        ld    = l;
        enb   = e;
        if (!r) begin
            m_cnt  = 0;
            m_disp = 0;
        end else begin
            if (e) m_cnt = (m_cnt + 1) % 1000;
            if (l) m_disp = m_cnt;
        end
        x.s2 = r ? seg_of(m_disp / 100) : 7'h40;
        x.s1 = r ? seg_of((m_disp / 10) % 10) : 7'h40;
        x.s0 = r ? seg_of(m_disp % 10) : 7'h40;
        x.c9 = r && e && (m_cnt == 999);
        exp_q.push_back(x);
        @(posedge ck);
        #1;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard: queue empty, expected 1 entry");
        end else begin
            got = exp_q.pop_front();
            check7("sb_sgm2", sgm2, got.s2);
            check7("sb_sgm1", sgm1, got.s1);
            check7("sb_sgm0", sgm0, got.s0);
            check1("sb_cnt_9", cnt_9, got.c9);
        end
    endtask

    initial begin
        vecs[0]  = '{"reset",    1'b0, 1'b0, 1'b0,   2, 7'h40, 7'h40, 7'h40, 1'b0};
        vecs[1]  = '{"count10",  1'b1, 1'b1, 1'b1,  10, 7'h40, 7'h79, 7'h40, 1'b0};
        vecs[2]  = '{"to099",    1'b1, 1'b1, 1'b1,  89, 7'h40, 7'h10, 7'h10, 1'b0};
        vecs[3]  = '{"carry100", 1'b1, 1'b1, 1'b1,   1, 7'h79, 7'h40, 7'h40, 1'b0};
        vecs[4]  = '{"to345",    1'b1, 1'b1, 1'b1, 245, 7'h30, 7'h19, 7'h12, 1'b0};
        vecs[5]  = '{"hold345",  1'b1, 1'b1, 1'b0,   5, 7'h30, 7'h19, 7'h12, 1'b0};
        vecs[6]  = '{"to567",    1'b1, 1'b1, 1'b1, 222, 7'h12, 7'h02, 7'h78, 1'b0};
        vecs[7]  = '{"rst_mid",  1'b0, 1'b1, 1'b1,   1, 7'h40, 7'h40, 7'h40, 1'b0};
        vecs[8]  = '{"to120",    1'b1, 1'b1, 1'b1, 120, 7'h79, 7'h24, 7'h40, 1'b0};
        vecs[9]  = '{"ld_off",   1'b1, 1'b0, 1'b1,   7, 7'h79, 7'h24, 7'h40, 1'b0};
        vecs[10] = '{"ld_on128", 1'b1, 1'b1, 1'b1,   1, 7'h79, 7'h24, 7'h00, 1'b0};
        vecs[11] = '{"to998",    1'b1, 1'b1, 1'b1, 870, 7'h10, 7'h10, 7'h00, 1'b0};
        vecs[12] = '{"at999",    1'b1, 1'b1, 1'b1,   1, 7'h10, 7'h10, 7'h10, 1'b1};
        vecs[13] = '{"hold999",  1'b1, 1'b1, 1'b0,   3, 7'h10, 7'h10, 7'h10, 1'b0};
        vecs[14] = '{"wrap000",  1'b1, 1'b1, 1'b1,   1, 7'h40, 7'h40, 7'h40, 1'b0};

        // Outputs while reset is held low, before any edge.
        #2;
        check7("pre_sgm0", sgm0, 7'h40);
        check1("pre_cnt_9", cnt_9, 1'b0);

        for (int v = 0; v < 15; v++) begin
            for (int k = 0; k < vecs[v].reps; k++)
                step(vecs[v].rst, vecs[v].l, vecs[v].e);
            check7({vecs[v].name, "_sgm2"}, sgm2, vecs[v].s2);
            check7({vecs[v].name, "_sgm1"}, sgm1, vecs[v].s1);
            check7({vecs[v].name, "_sgm0"}, sgm0, vecs[v].s0);
            check1({vecs[v].name, "_cnt_9"}, cnt_9, vecs[v].c9);
            $display("step %-9s rst_s=%b ld=%b enb=%b x%0d -> sgm2=%h sgm1=%h sgm0=%h cnt_9=%b",
                     vecs[v].name, vecs[v].rst, vecs[v].l, vecs[v].e, vecs[v].reps,
                     sgm2, sgm1, sgm0, cnt_9);
        end

        // Reset overrides a dropped latch: displays clear even with ld=0.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b1);
        check7("cnt005_sgm0", sgm0, 7'h12);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check7("rst_ld0_sgm0", sgm0, 7'h40);
        check7("rst_ld0_sgm2", sgm2, 7'h40);
        $display("step rst_ld0   -> sgm2=%h sgm1=%h sgm0=%h cnt_9=%b", sgm2, sgm1, sgm0, cnt_9);

        // Counting resumes from 000 after that reset: first enabled edge gives 001.
        step(1'b1, 1'b1, 1'b1);
        check7("resume_sgm0", sgm0, 7'h79);
        check7("resume_sgm1", sgm1, 7'h40);
        $display("step resume    -> sgm2=%h sgm1=%h sgm0=%h cnt_9=%b", sgm2, sgm1, sgm0, cnt_9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
